// File: rtl/gate_sweep_checker.sv
// Sequencer that sweeps a two-input gate block through vectors 00..11 and
// checks its six outputs. Optional macro GATE_SWEEP_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_sweep_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int SWEEPS      = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gate_in1,
  output logic             gate_in2,
  input  logic             res_and,
  input  logic             res_or,
  input  logic             res_not,
  input  logic             res_nand,
  input  logic             res_nor,
  input  logic             res_xor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [5:0]       fail_bits
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Expected gate outputs, ordered {xor,nor,nand,not,or,and}.
  function automatic logic [5:0] expected_res(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SW-1:0]    sweep_q, sweep_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fvec_q, fvec_d;
  logic [5:0]       fbits_q, fbits_d;
  logic             in1_q, in1_d, in2_q, in2_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [5:0]       mask;
  logic             stop;
  logic             last;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    sweep_d = sweep_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fbits_d = fbits_q;
    mask    = expected_res(vec_q) ^
              {res_xor, res_nor, res_nand, res_not, res_or, res_and};
    last    = (vec_q == 2'd3) && (sweep_q == SWEEP_LAST);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    stop    = |mask;
`else
    stop    = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          hold_d  = '0;
          sweep_d = '0;
          err_d   = '0;
          fvec_d  = '0;
          fbits_d = '0;
        end
      end
      S_RUN: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (|mask) begin
            err_d = sat_inc(err_q);
            // Only the first failure of a run is recorded.
            if (err_q == '0) begin
              fvec_d  = vec_q;
              fbits_d = mask;
            end
          end
          if (last || stop) begin
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 2'd1;
            if (vec_q == 2'd3) sweep_d = sweep_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next state so they come straight off flops.
    in1_d  = (state_d == S_RUN) & vec_d[1];
    in2_d  = (state_d == S_RUN) & vec_d[0];
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      sweep_q <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fbits_q <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fbits_q <= fbits_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign gate_in1  = in1_q;
  assign gate_in2  = in2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;
  assign fail_bits = fbits_q;

endmodule
